// File: rtl/conv_block_sequencer.sv
// -----------------------------------------------------------------------------
// conv_block_sequencer
//
// Top-level sequencer for the 2D-convolution engine. It walks an image made
// of N column blocks through the per-block address FSM: load block k from the
// host, let the address FSM process it, let the host read it back, then move
// on to block k+1. A watchdog aborts the image if any active phase stalls.
//
// Ports
//   i_CLK          clock, all logic on the rising edge
//   i_reset        synchronous, active-high reset
//   i_start        start-of-image pulse, accepted only while idle
//   i_numBlocks    number of column blocks, sampled at start
//   i_imgLength    image height, sampled at start
//   i_hostLast     host pulse: last row of the current block has been sent
//   i_changeBlock  block-complete pulse from the address FSM
//   i_EoP          end-of-process flag from the address FSM
//   o_load         load control to the address FSM
//   o_SoP          start-of-process control to the address FSM
//   o_imgLength    image height latched at start, held for the whole image
//   o_blockIdx     index of the block currently being handled
//   o_reqData      host may stream block data
//   o_reqRead      host may read back the processed block
//   o_busy         high in every state except idle
//   o_done         one-cycle pulse when the last block has been read out
//   o_error        sticky watchdog error, cleared by the next accepted start
// -----------------------------------------------------------------------------
module conv_block_sequencer #(
    parameter int NB_IMAGE   = 10,
    parameter int NB_BLOCK   = 4,
    parameter int NB_TIMEOUT = 16
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BLOCK-1:0] i_numBlocks,
    input  logic [NB_IMAGE-1:0] i_imgLength,
    input  logic                i_hostLast,
    input  logic                i_changeBlock,
    input  logic                i_EoP,
    output logic                o_load,
    output logic                o_SoP,
    output logic [NB_IMAGE-1:0] o_imgLength,
    output logic [NB_BLOCK-1:0] o_blockIdx,
    output logic                o_reqData,
    output logic                o_reqRead,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_WAIT,
        S_PROC,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [NB_BLOCK-1:0]   BLK_ONE  = NB_BLOCK'(1);
    localparam logic [NB_TIMEOUT-1:0] WDOG_ONE = NB_TIMEOUT'(1);
    localparam logic [NB_TIMEOUT-1:0] WDOG_MAX = '1;

    state_t                state_q, state_d;
    logic [NB_BLOCK-1:0]   num_blocks_q, num_blocks_d;
    logic [NB_BLOCK-1:0]   block_idx_q, block_idx_d;
    logic [NB_IMAGE-1:0]   img_length_q, img_length_d;
    logic [NB_TIMEOUT-1:0] wdog_q, wdog_d;
    logic                  error_q, error_d;
    logic                  load_q, load_d;
    logic                  sop_q, sop_d;
    logic                  req_data_q, req_data_d;
    logic                  req_read_q, req_read_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [NB_TIMEOUT-1:0] wdog_inc;
    logic                  active;

    always_comb begin
        state_d      = state_q;
        num_blocks_d = num_blocks_q;
        block_idx_d  = block_idx_q;
        img_length_d = img_length_q;
        error_d      = error_q;
        wdog_d       = '0;
        wdog_inc     = wdog_q + WDOG_ONE;
        active       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A zero-block image has nothing to do, so its start is dropped.
                if (i_start && (i_numBlocks != '0)) begin
                    num_blocks_d = i_numBlocks;
                    img_length_d = i_imgLength;
                    block_idx_d  = '0;
                    error_d      = 1'b0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                active = 1'b1;
                if (i_hostLast) begin
                    state_d = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: begin
                active = 1'b1;
                if (i_changeBlock) begin
                    state_d = S_PROC;
                end
            end
            S_PROC: begin
                active = 1'b1;
                if (i_EoP) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                active = 1'b1;
                if (i_changeBlock) begin
                    if (block_idx_q == (num_blocks_q - BLK_ONE)) begin
                        state_d = S_DONE;
                    end else begin
                        block_idx_d = block_idx_q + BLK_ONE;
                        state_d     = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog: counts consecutive cycles spent in one active state. It
        // fires on the cycle that would take it to all-ones, i.e. after
        // 2^NB_TIMEOUT-1 stalled cycles; any state change restarts it at 0.
        if (active && (state_d == state_q)) begin
            if (wdog_inc == WDOG_MAX) begin
                state_d = S_IDLE;
                error_d = 1'b1;
            end else begin
                wdog_d = wdog_inc;
            end
        end

        // Outputs are a registered decode of the next state so they line up
        // with the state they describe.
        load_d     = (state_d == S_LOAD);
        req_data_d = (state_d == S_LOAD);
        sop_d      = (state_d == S_PROC);
        req_read_d = (state_d == S_READ);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            num_blocks_q <= '0;
            block_idx_q  <= '0;
            img_length_q <= '0;
            wdog_q       <= '0;
            error_q      <= 1'b0;
            load_q       <= 1'b0;
            sop_q        <= 1'b0;
            req_data_q   <= 1'b0;
            req_read_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_blocks_q <= num_blocks_d;
            block_idx_q  <= block_idx_d;
            img_length_q <= img_length_d;
            wdog_q       <= wdog_d;
            error_q      <= error_d;
            load_q       <= load_d;
            sop_q        <= sop_d;
            req_data_q   <= req_data_d;
            req_read_q   <= req_read_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_load      = load_q;
    assign o_SoP       = sop_q;
    assign o_imgLength = img_length_q;
    assign o_blockIdx  = block_idx_q;
    assign o_reqData   = req_data_q;
    assign o_reqRead   = req_read_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_conv_block_sequencer.sv
module tb_conv_block_sequencer;

    localparam int NB_IMAGE   = 10;
    localparam int NB_BLOCK   = 4;
    localparam int NB_TIMEOUT = 4;
    localparam int TO_CYC     = (1 << NB_TIMEOUT) - 1;

    logic                clk = 1'b0;
    logic                i_reset = 1'b0;
    logic                i_start = 1'b0;
    logic [NB_BLOCK-1:0] i_numBlocks = '0;
    logic [NB_IMAGE-1:0] i_imgLength = '0;
    logic                i_hostLast = 1'b0;
    logic                i_changeBlock = 1'b0;
    logic                i_EoP = 1'b0;
    logic                o_load, o_SoP, o_reqData, o_reqRead, o_busy, o_done, o_error;
    logic [NB_IMAGE-1:0] o_imgLength;
    logic [NB_BLOCK-1:0] o_blockIdx;

    always #5 clk = ~clk;

    conv_block_sequencer #(
        .NB_IMAGE  (NB_IMAGE),
        .NB_BLOCK  (NB_BLOCK),
        .NB_TIMEOUT(NB_TIMEOUT)
    ) dut (
        .i_CLK        (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_numBlocks  (i_numBlocks),
        .i_imgLength  (i_imgLength),
        .i_hostLast   (i_hostLast),
        .i_changeBlock(i_changeBlock),
        .i_EoP        (i_EoP),
        .o_load       (o_load),
        .o_SoP        (o_SoP),
        .o_imgLength  (o_imgLength),
        .o_blockIdx   (o_blockIdx),
        .o_reqData    (o_reqData),
        .o_reqRead    (o_reqRead),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    // Phase of the image as the bench intends it (transaction view).
    typedef enum {P_IDLE, P_LOAD, P_LW, P_PROC, P_READ, P_DONE} ph_e;

    typedef struct packed {
        logic       load;
        logic       sop;
        logic       rdata;
        logic       rread;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] blk;
        logic [9:0] img;
    } out_t;

    typedef struct {
        bit         rst;
        bit         start;
        logic [3:0] nb;
        logic [9:0] img;
        bit         hl;
        bit         cb;
        bit         eop;
        int         reps;
        out_t       exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_rd = 0, cnt_rr = 0, cnt_done = 0;
    bit prev_rd = 1'b0, prev_rr = 1'b0;

    ph_e        ph = P_IDLE;
    int         dwell = 1;
    logic [3:0] e_blk = '0;
    logic [9:0] e_img = '0;
    bit         e_err = 1'b0;

    vec_t tbl[$];

    function automatic out_t eo(int ld, int sp, int rd, int rr, int bz, int dn, int er, int blk, int img);
        out_t e;
        e.load  = (ld != 0);
        e.sop   = (sp != 0);
        e.rdata = (rd != 0);
        e.rread = (rr != 0);
        e.busy  = (bz != 0);
        e.done  = (dn != 0);
        e.err   = (er != 0);
        e.blk   = 4'(blk);
        e.img   = 10'(img);
        return e;
    endfunction

    function automatic vec_t mk(int rst, int st, int nb, int img, int hl, int cb, int eop, int reps, out_t e);
        vec_t v;
        v.rst   = (rst != 0);
        v.start = (st != 0);
        v.nb    = 4'(nb);
        v.img   = 10'(img);
        v.hl    = (hl != 0);
        v.cb    = (cb != 0);
        v.eop   = (eop != 0);
        v.reps  = reps;
        v.exp   = e;
        return v;
    endfunction

    // Expected outputs for the phase the image is in.
    function automatic out_t model_out();
        out_t e;
        e.load  = (ph == P_LOAD);
        e.rdata = (ph == P_LOAD);
        e.sop   = (ph == P_PROC);
        e.rread = (ph == P_READ);
        e.busy  = (ph != P_IDLE);
        e.done  = (ph == P_DONE);
        e.err   = e_err;
        e.blk   = e_blk;
        e.img   = e_img;
        return e;
    endfunction

    task automatic check(input string nm, input out_t exp);
        out_t g;
        g = '{o_load, o_SoP, o_reqData, o_reqRead, o_busy, o_done, o_error, o_blockIdx, o_imgLength};
        n_cmp++;
        if (g !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got load=%0b sop=%0b rdata=%0b rread=%0b busy=%0b done=%0b err=%0b blk=%0d img=%0d | required load=%0b sop=%0b rdata=%0b rread=%0b busy=%0b done=%0b err=%0b blk=%0d img=%0d",
                     nm, $time, g.load, g.sop, g.rdata, g.rread, g.busy, g.done, g.err, g.blk, g.img,
                     exp.load, exp.sop, exp.rdata, exp.rread, exp.busy, exp.done, exp.err, exp.blk, exp.img);
        end
        n_cmp++;
        if (g.load && g.sop) begin
            n_bad++;
            $display("FAIL %s load_sop_overlap t=%0t got load=1 sop=1, required never both high", nm, $time);
        end
        if (g.rdata && !prev_rd) cnt_rd++;
        if (g.rread && !prev_rr) cnt_rr++;
        if (g.done) cnt_done++;
        prev_rd = g.rdata;
        prev_rr = g.rread;
    endtask

    task automatic cmp_int(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got %0d required %0d", nm, got, exp);
        end
    endtask

    // One clock: 'want' is the phase the applied inputs should lead to. A
    // stalled active phase is forced to IDLE with error on its 15th cycle.
    task automatic step(input ph_e want, input string nm);
        ph_e nxt;
        nxt = want;
        if ((want == ph) && (ph inside {P_LOAD, P_LW, P_PROC, P_READ}) && (dwell == TO_CYC)) begin
            nxt   = P_IDLE;
            e_err = 1'b1;
        end
        if (nxt == ph) dwell++;
        else dwell = 1;
        ph = nxt;
        @(posedge clk);
        #1;
        i_start = 1'b0; i_hostLast = 1'b0; i_changeBlock = 1'b0; i_EoP = 1'b0; i_reset = 1'b0;
        check(nm, model_out());
    endtask

    task automatic do_reset(input string nm);
        i_reset = 1'b1;
        e_blk = '0; e_img = '0; e_err = 1'b0;
        step(P_IDLE, nm);
    endtask

    task automatic start(input logic [3:0] nb, input logic [9:0] img, input string nm);
        ph_e w;
        w = ph;
        i_start = 1'b1; i_numBlocks = nb; i_imgLength = img;
        if ((ph == P_IDLE) && (nb != 4'd0)) begin
            e_blk = '0; e_img = img; e_err = 1'b0;
            w = P_LOAD;
        end
        step(w, nm);
    endtask

    // Hold the current phase for n cycles, optionally with pulses that the
    // current phase must ignore. Stops early if the phase is left (timeout).
    task automatic idle_cycles(input int n, input bit stray, input string nm);
        ph_e p0;
        p0 = ph;
        for (int i = 0; i < n; i++) begin
            if (ph != p0) break;
            if (stray && ($urandom_range(0, 2) == 0)) begin
                case ($urandom_range(0, 3))
                    0: if (ph != P_LOAD) i_hostLast = 1'b1;
                    1: if (ph != P_LW && ph != P_READ) i_changeBlock = 1'b1;
                    2: if (ph != P_PROC) i_EoP = 1'b1;
                    default: if (ph != P_IDLE) begin
                        i_start = 1'b1;
                        i_numBlocks = 4'($urandom_range(0, 15));
                        i_imgLength = 10'($urandom);
                    end
                endcase
            end
            step(ph, nm);
        end
    endtask

    function automatic int wt(input int w, input bit rnd);
        return rnd ? int'($urandom_range(0, w)) : w;
    endfunction

    task automatic run_block(input bit last, input int w, input bit rnd, input bit stray, input string nm);
        idle_cycles(wt(w, rnd), stray, nm);
        if (ph != P_LOAD) return;
        i_hostLast = 1'b1; step(P_LW, nm);
        idle_cycles(wt(w, rnd), stray, nm);
        if (ph != P_LW) return;
        i_changeBlock = 1'b1; step(P_PROC, nm);
        idle_cycles(wt(w, rnd), stray, nm);
        if (ph != P_PROC) return;
        i_EoP = 1'b1; step(P_READ, nm);
        idle_cycles(wt(w, rnd), stray, nm);
        if (ph != P_READ) return;
        i_changeBlock = 1'b1;
        if (last) begin
            step(P_DONE, nm);
        end else begin
            e_blk = e_blk + 4'd1;
            step(P_LOAD, nm);
        end
    endtask

    task automatic run_image(input int nb, input int img, input int w, input bit rnd, input bit stray, input string nm);
        start(4'(nb), 10'(img), nm);
        if (ph != P_LOAD) return;
        for (int b = 0; b < nb; b++) begin
            run_block(b == nb - 1, w, rnd, stray, nm);
            if (ph == P_IDLE) return;
        end
        step(P_IDLE, nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit reached, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        int s_rd, s_rr, s_dn, hit;

        // Single-block image, one record per stable stretch of cycles.
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 2,  eo(0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 1, 10, 0, 0, 0, 1,  eo(1, 0, 1, 0, 1, 0, 0, 0, 10)));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 11, eo(1, 0, 1, 0, 1, 0, 0, 0, 10)));
        tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 1,  eo(0, 0, 0, 0, 1, 0, 0, 0, 10)));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 2,  eo(0, 0, 0, 0, 1, 0, 0, 0, 10)));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 1,  eo(0, 1, 0, 0, 1, 0, 0, 0, 10)));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 9,  eo(0, 1, 0, 0, 1, 0, 0, 0, 10)));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 1, 1,  eo(0, 0, 0, 1, 1, 0, 0, 0, 10)));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 3,  eo(0, 0, 0, 1, 1, 0, 0, 0, 10)));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 1,  eo(0, 0, 0, 0, 1, 1, 0, 0, 10)));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 3,  eo(0, 0, 0, 0, 0, 0, 0, 0, 10)));

        for (int k = 0; k < tbl.size(); k++) begin
            for (int r = 0; r < tbl[k].reps; r++) begin
                i_reset = tbl[k].rst; i_start = tbl[k].start;
                i_numBlocks = tbl[k].nb; i_imgLength = tbl[k].img;
                i_hostLast = tbl[k].hl; i_changeBlock = tbl[k].cb; i_EoP = tbl[k].eop;
                @(posedge clk);
                #1;
                check($sformatf("single_blk_row%0d", k), tbl[k].exp);
            end
        end
        i_reset = 1'b0; i_start = 1'b0; i_hostLast = 1'b0; i_changeBlock = 1'b0; i_EoP = 1'b0;
        ph = P_IDLE; dwell = 1; e_blk = '0; e_img = 10'd10; e_err = 1'b0;

        // Three blocks: index walks 0,1,2; three loads, three read-outs, one done.
        s_rd = cnt_rd; s_rr = cnt_rr; s_dn = cnt_done;
        run_image(3, 10, 2, 1'b0, 1'b0, "three_blk");
        cmp_int("three_blk_reqData_count", cnt_rd - s_rd, 3);
        cmp_int("three_blk_reqRead_count", cnt_rr - s_rr, 3);
        cmp_int("three_blk_done_count", cnt_done - s_dn, 1);
        cmp_int("three_blk_final_idx", int'(o_blockIdx), 2);

        // Zero-block start is dropped; a start while processing is ignored.
        start(4'd0, 10'd5, "zero_start");
        idle_cycles(2, 1'b0, "zero_start_idle");
        start(4'd1, 10'd10, "overlap_start");
        i_hostLast = 1'b1; step(P_LW, "overlap_lw");
        i_changeBlock = 1'b1; step(P_PROC, "overlap_proc");
        idle_cycles(2, 1'b0, "overlap_proc");
        start(4'd2, 10'd20, "overlap_restart");
        idle_cycles(1, 1'b0, "overlap_proc");
        cmp_int("overlap_imgLength_kept", int'(o_imgLength), 10);
        i_EoP = 1'b1; step(P_READ, "overlap_read");
        i_changeBlock = 1'b1; step(P_DONE, "overlap_done");
        step(P_IDLE, "overlap_idle");

        // Stray pulses: changeBlock during LOAD and EoP during READ.
        start(4'd2, 10'd33, "stray_start");
        i_changeBlock = 1'b1; step(P_LOAD, "stray_cb_in_load");
        i_EoP = 1'b1; step(P_LOAD, "stray_eop_in_load");
        i_hostLast = 1'b1; step(P_LW, "stray_lw");
        i_hostLast = 1'b1; step(P_LW, "stray_hl_in_lw");
        i_changeBlock = 1'b1; step(P_PROC, "stray_proc");
        i_changeBlock = 1'b1; step(P_PROC, "stray_cb_in_proc");
        i_EoP = 1'b1; step(P_READ, "stray_read");
        i_EoP = 1'b1; step(P_READ, "stray_eop_in_read");
        i_changeBlock = 1'b1; e_blk = 4'd1; step(P_LOAD, "stray_next_blk");
        run_block(1'b1, 1, 1'b0, 1'b0, "stray_blk1");
        step(P_IDLE, "stray_idle");

        // Watchdog: withhold EoP; error must appear after the 15th stalled cycle.
        s_dn = cnt_done;
        start(4'd1, 10'd7, "wd_start");
        i_hostLast = 1'b1; step(P_LW, "wd_lw");
        i_changeBlock = 1'b1; step(P_PROC, "wd_proc");
        hit = 0;
        for (int i = 1; i <= 20; i++) begin
            step(P_PROC, "wd_stall");
            if (o_error === 1'b1) begin
                hit = i;
                break;
            end
        end
        cmp_int("wd_stall_cycles", hit, TO_CYC);
        idle_cycles(2, 1'b0, "wd_after");
        cmp_int("wd_no_done", cnt_done - s_dn, 0);
        start(4'd1, 10'd8, "wd_restart_clears_error");
        run_block(1'b1, 1, 1'b0, 1'b0, "wd_restart_blk");
        step(P_IDLE, "wd_restart_idle");

        // Reset during read-out of block 1, then a clean two-block image.
        start(4'd2, 10'd12, "rst_start");
        run_block(1'b0, 1, 1'b0, 1'b0, "rst_blk0");
        i_hostLast = 1'b1; step(P_LW, "rst_blk1_lw");
        i_changeBlock = 1'b1; step(P_PROC, "rst_blk1_proc");
        i_EoP = 1'b1; step(P_READ, "rst_blk1_read");
        idle_cycles(1, 1'b0, "rst_blk1_read");
        do_reset("rst_mid_read");
        s_dn = cnt_done;
        run_image(2, 15, 3, 1'b0, 1'b0, "rst_fresh_image");
        cmp_int("rst_fresh_done_count", cnt_done - s_dn, 1);

        // Randomized images, including occasional over-long stalls and strays.
        for (int it = 0; it < 40; it++) begin
            int nb, w;
            nb = $urandom_range(0, 4);
            w  = ($urandom_range(0, 7) == 0) ? 16 : 5;
            run_image(nb, int'($urandom_range(0, 1023)), w, 1'b1, bit'($urandom_range(0, 1)),
                      $sformatf("rand%0d", it));
            idle_cycles(int'($urandom_range(0, 2)), 1'b0, $sformatf("rand%0d_gap", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
